uart_tx_byte_feeder: RTL and testbench

Byte-queue and handshake stage directly upstream of the UART transmit FSM/serializer. Accepts single bytes or 16-bit words (for example, ALU results) from the system controller and buffers them as bytes in a small FIFO. It presents one byte at a time to the transmitter with a single-cycle data-valid pulse, then waits for the transmitter's busy signal to rise and fall before issuing the next byte. All logic runs in the UART TX clock domain.

---
 rtl/uart_tx_byte_feeder.sv | 119 +++++++++++
 tb/tb_uart_tx_byte_feeder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_byte_feeder.sv
// Byte FIFO plus start/busy handshake that feeds the UART transmit FSM one byte
// per frame; accepts narrow (1-byte) or wide (2-byte, low byte first) writes.
module uart_tx_byte_feeder #(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_EN,
  input  logic        WR_WIDE,
  input  logic [15:0] WR_DATA,
  input  logic        CLR_OVF,
  input  logic        TX_BUSY,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_DATA_VALID,
  output logic        FULL,
  output logic        ALMOST_FULL,
  output logic        EMPTY,
  output logic        OVERFLOW,
  output logic [1:0]  DBG_STATE
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_M1   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_M2   = CW'(DEPTH - 2);

  // Handshake: TX_DATA_VALID is a one-cycle start request; the next request is
  // only issued after TX_BUSY has been seen high (WAIT_HI) and then low (WAIT_LO).
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_HI = 2'd1,
    S_WAIT_LO = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];

  logic            acc_narrow, acc_wide, accept, reject, pop;
  logic [CW-1:0]   push_n;

  // Acceptance always uses the pre-edge count, so a same-cycle pop never makes room.
  assign acc_narrow = WR_EN && !WR_WIDE && (count_q <= CNT_M1);
  assign acc_wide   = WR_EN &&  WR_WIDE && (count_q <= CNT_M2);
  assign accept     = acc_narrow || acc_wide;
  assign reject     = WR_EN && !accept;
  assign push_n     = acc_wide ? CW'(2) : (acc_narrow ? CW'(1) : CW'(0));
  assign wr_ptr_p1  = wr_ptr_q + AW'(1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !TX_BUSY) begin
          data_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          pop     = 1'b1;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (TX_BUSY)  state_d = S_WAIT_LO;
      S_WAIT_LO: if (!TX_BUSY) state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        data_d  = 8'h00;
      end
    endcase
  end

  always_comb begin
    count_d  = count_q + push_n - {{(CW-1){1'b0}}, pop};
    wr_ptr_d = wr_ptr_q + AW'(push_n);
    rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
    ovf_d    = reject ? 1'b1 : (CLR_OVF ? 1'b0 : ovf_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (accept) mem_q[wr_ptr_q] <= WR_DATA[7:0];
    if (acc_wide) mem_q[wr_ptr_p1] <= WR_DATA[15:8];
  end

  assign TX_P_DATA     = data_q;
  assign TX_DATA_VALID = valid_q;
  assign FULL          = (count_q == CNT_FULL);
  assign ALMOST_FULL   = (count_q >= CNT_M1);
  assign EMPTY         = (count_q == '0);
  assign OVERFLOW      = ovf_q;
  assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_uart_tx_byte_feeder.sv
// Directed bench for uart_tx_byte_feeder: flag-vector table plus hand-written
// handshake/corner sequences, with a TX FSM model checking every presented byte.
module tb_uart_tx_byte_feeder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WR_EN = 1'b0;
  logic        WR_WIDE = 1'b0;
  logic [15:0] WR_DATA = 16'h0000;
  logic        CLR_OVF = 1'b0;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VALID, FULL, ALMOST_FULL, EMPTY, OVERFLOW;
  logic [1:0]  DBG_STATE;

  logic        stall = 1'b1;
  logic        model_busy = 1'b0;
  logic        prev_v = 1'b0;
  logic        gap_chk = 1'b0;
  int          busy_cnt = 0;
  int          nedge = 0;
  int          last_fall = -1;
  int          pulse_cnt = 0;
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        en;
    logic        wide;
    logic [15:0] data;
    logic        clr;
    logic        acc;
    logic        full;
    logic        afull;
    logic        empty;
    logic        ovf;
  } vec_t;

  vec_t tbl[10];

  assign TX_BUSY = stall | model_busy;

  uart_tx_byte_feeder #(.DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_WIDE(WR_WIDE), .WR_DATA(WR_DATA),
    .CLR_OVF(CLR_OVF), .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA),
    .TX_DATA_VALID(TX_DATA_VALID), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
    .EMPTY(EMPTY), .OVERFLOW(OVERFLOW), .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // TX FSM model: busy rises right after it samples the pulse, stays up 11 cycles.
  always @(negedge CLK) begin
    nedge++;
    if (RST) begin
      busy_cnt   = 0;
      model_busy = 1'b0;
      prev_v     = 1'b0;
    end else begin
      if (TX_DATA_VALID) begin
        chk("valid_width", {15'd0, prev_v}, 16'd0);
        chk("valid_while_busy", {15'd0, TX_BUSY}, 16'd0);
        if (gap_chk && last_fall >= 0) chk("restart_gap", 16'(nedge - last_fall), 16'd2);
        chk("byte_expected", {15'd0, exp_q.size() != 0}, 16'd1);
        if (exp_q.size() != 0) chk("tx_byte", {8'd0, TX_P_DATA}, {8'd0, exp_q.pop_front()});
        pulse_cnt++;
        model_busy = 1'b1;
        busy_cnt   = 11;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          model_busy = 1'b0;
          last_fall  = nedge;
        end
      end
      prev_v = TX_DATA_VALID;
    end
  end

  task automatic apply(input vec_t v, input int idx);
    @(negedge CLK);
    WR_EN = v.en; WR_WIDE = v.wide; WR_DATA = v.data; CLR_OVF = v.clr;
    if (v.en && v.acc) begin
      exp_q.push_back(v.data[7:0]);
      if (v.wide) exp_q.push_back(v.data[15:8]);
    end
    @(posedge CLK); #1;
    WR_EN = 1'b0; WR_WIDE = 1'b0; CLR_OVF = 1'b0;
    chk($sformatf("vec%0d_full", idx),  {15'd0, FULL},        {15'd0, v.full});
    chk($sformatf("vec%0d_afull", idx), {15'd0, ALMOST_FULL}, {15'd0, v.afull});
    chk($sformatf("vec%0d_empty", idx), {15'd0, EMPTY},       {15'd0, v.empty});
    chk($sformatf("vec%0d_ovf", idx),   {15'd0, OVERFLOW},    {15'd0, v.ovf});
  endtask

  task automatic wr(input logic wide, input logic [15:0] d, input logic acc);
    @(negedge CLK);
    WR_EN = 1'b1; WR_WIDE = wide; WR_DATA = d;
    if (acc) begin
      exp_q.push_back(d[7:0]);
      if (wide) exp_q.push_back(d[15:8]);
    end
    @(posedge CLK); #1;
    WR_EN = 1'b0; WR_WIDE = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    for (int i = 0; i < 600 && quiet < 3; i++) begin
      @(posedge CLK); #1;
      if (EMPTY && !TX_BUSY && !TX_DATA_VALID) quiet++;
      else quiet = 0;
    end
    chk({name, "_drain_done"}, {15'd0, quiet >= 3}, 16'd1);
    chk({name, "_all_sent"}, 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b0, 16'h0010 + 16'(i), 1'b0, 1'b1, i == 7, i >= 6, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 16'h00EE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_data",  {8'd0, TX_P_DATA}, 16'h0000);
    chk("rst_valid", {15'd0, TX_DATA_VALID}, 16'd0);
    chk("rst_full",  {15'd0, FULL}, 16'd0);
    chk("rst_afull", {15'd0, ALMOST_FULL}, 16'd0);
    chk("rst_empty", {15'd0, EMPTY}, 16'd1);
    chk("rst_ovf",   {15'd0, OVERFLOW}, 16'd0);

    // Fill with TX stalled, one rejected write, clear; then drain in order
    for (int i = 0; i < 10; i++) apply(tbl[i], i);
    stall = 1'b0;
    wait_idle("fill");

    // Start latency: valid high after N+1, low again after N+2
    @(negedge CLK);
    WR_EN = 1'b1; WR_WIDE = 1'b0; WR_DATA = 16'h0042; exp_q.push_back(8'h42);
    @(posedge CLK); #1; WR_EN = 1'b0;
    chk("lat_empty", {15'd0, EMPTY}, 16'd0);
    chk("lat_v_n",   {15'd0, TX_DATA_VALID}, 16'd0);
    @(posedge CLK); #1;
    chk("lat_v_n1",  {15'd0, TX_DATA_VALID}, 16'd1);
    chk("lat_data",  {8'd0, TX_P_DATA}, 16'h0042);
    @(posedge CLK); #1;
    chk("lat_v_n2",  {15'd0, TX_DATA_VALID}, 16'd0);
    chk("lat_hold",  {8'd0, TX_P_DATA}, 16'h0042);
    wait_idle("lat");

    // Wide write: 5A then A5, two pulses, second 2 edges after busy falls
    begin
      int p0;
      p0 = pulse_cnt;
      last_fall = -1;
      gap_chk = 1'b1;
      wr(1'b1, 16'hA55A, 1'b1);
      wait_idle("wide");
      gap_chk = 1'b0;
      chk("wide_pulses", 16'(pulse_cnt - p0), 16'd2);
      chk("wide_last",   {8'd0, TX_P_DATA}, 16'h00A5);
    end

    // Count 7: wide rejected, narrow accepted; then full + pop + clr + reject
    stall = 1'b1;
    for (int i = 0; i < 7; i++) wr(1'b0, 16'h0030 + 16'(i), 1'b1);
    chk("c7_afull", {15'd0, ALMOST_FULL}, 16'd1);
    chk("c7_full",  {15'd0, FULL}, 16'd0);
    wr(1'b1, 16'hBBCC, 1'b0);
    chk("c7w_afull", {15'd0, ALMOST_FULL}, 16'd1);
    chk("c7w_full",  {15'd0, FULL}, 16'd0);
    chk("c7w_ovf",   {15'd0, OVERFLOW}, 16'd1);
    wr(1'b0, 16'h0037, 1'b1);
    chk("c8_full", {15'd0, FULL}, 16'd1);
    chk("c8_ovf",  {15'd0, OVERFLOW}, 16'd1);
    @(negedge CLK);
    stall = 1'b0; WR_EN = 1'b1; WR_WIDE = 1'b0; WR_DATA = 16'h00DD; CLR_OVF = 1'b1;
    @(posedge CLK); #1;
    WR_EN = 1'b0; CLR_OVF = 1'b0;
    chk("pp_full",  {15'd0, FULL}, 16'd0);
    chk("pp_afull", {15'd0, ALMOST_FULL}, 16'd1);
    chk("pp_ovf",   {15'd0, OVERFLOW}, 16'd1);
    chk("pp_valid", {15'd0, TX_DATA_VALID}, 16'd1);
    @(negedge CLK); CLR_OVF = 1'b1;
    @(posedge CLK); #1; CLR_OVF = 1'b0;
    chk("clr_ovf", {15'd0, OVERFLOW}, 16'd0);
    wait_idle("c8");

    // Pointer wrap: 20 bytes streamed while draining
    for (int i = 0; i < 20; i++) begin
      wr(1'b0, 16'(i), 1'b1);
      repeat (12) @(posedge CLK);
    end
    wait_idle("wrap");
    chk("wrap_empty", {15'd0, EMPTY}, 16'd1);
    chk("wrap_last",  {8'd0, TX_P_DATA}, 16'h0013);

    // Asynchronous reset while the start pulse is high
    wr(1'b0, 16'h0077, 1'b1);
    wr(1'b0, 16'h0078, 1'b1);
    chk("prerst_valid", {15'd0, TX_DATA_VALID}, 16'd1);
    chk("prerst_empty", {15'd0, EMPTY}, 16'd0);
    #1 RST = 1'b1;
    #1;
    exp_q.delete();
    chk("mrst_valid", {15'd0, TX_DATA_VALID}, 16'd0);
    chk("mrst_empty", {15'd0, EMPTY}, 16'd1);
    chk("mrst_data",  {8'd0, TX_P_DATA}, 16'h0000);
    chk("mrst_full",  {15'd0, FULL}, 16'd0);
    chk("mrst_ovf",   {15'd0, OVERFLOW}, 16'd0);
    @(negedge CLK); RST = 1'b0;
    wr(1'b0, 16'h0055, 1'b1);
    wait_idle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
